mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that gives NREQ requesters shared access to a single-port memory.
// It handles one access at a time. Reads return through a shared response bus with a fixed latency.
module mem_arbiter #(
    parameter int NREQ   = 3,
    parameter int TW     = 2,
    parameter int XW     = 5,
    parameter int YW     = 5,
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*TW-1:0]   req_t,
    input  logic [NREQ*XW-1:0]   req_x,
    input  logic [NREQ*YW-1:0]   req_y,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [TW-1:0]        mem_t,
    output logic [XW-1:0]        mem_x,
    output logic [YW-1:0]        mem_y,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   cur;
    logic            cur_write;
    logic [CW-1:0]   cnt;

    logic            found;
    logic [PW-1:0]   gnt;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   ptr_next;
    logic            sel_write;
    logic [TW-1:0]   sel_t;
    logic [XW-1:0]   sel_x;
    logic [YW-1:0]   sel_y;
    logic [DW-1:0]   sel_wdata;

    // Scan the requesters starting at ptr; the first valid one wins.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    always_comb begin
        sel_write = req_write[gnt];
        sel_t     = req_t[int'(gnt)*TW +: TW];
        sel_x     = req_x[int'(gnt)*XW +: XW];
        sel_y     = req_y[int'(gnt)*YW +: YW];
        sel_wdata = req_wdata[int'(gnt)*DW +: DW];
        ptr_next  = (int'(gnt) == NREQ - 1) ? '0 : gnt + PW'(1);
    end

    assign req_ready = (state == IDLE && !reset && found) ? (NREQ'(1) << gnt) : '0;

    // WAIT runs RD_LAT+1 cycles after the mem_rd cycle, so the response shows up RD_LAT+2 cycles after accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cur       <= '0;
            cur_write <= 1'b0;
            cnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_t     <= '0;
            mem_x     <= '0;
            mem_y     <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cur       <= gnt;
                        cur_write <= sel_write;
                        mem_t     <= sel_t;
                        mem_x     <= sel_x;
                        mem_y     <= sel_y;
                        mem_wdata <= sel_wdata;
                        mem_rd    <= !sel_write;
                        mem_wr    <= sel_write;
                        ptr       <= ptr_next;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    cnt    <= '0;
                    state  <= cur_write ? IDLE : WAIT;
                end
                WAIT: begin
                    if (cnt == CW'(RD_LAT)) begin
                        rsp_data  <= mem_rdata;
                        rsp_valid <= NREQ'(1) << cur;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: runs a table of single transactions, then hand-written sequences
// for fairness, pointer wrap, reset during a read, and back-to-back writes.
module tb_mem_arbiter;

    localparam int NREQ   = 3;
    localparam int TW     = 2;
    localparam int XW     = 5;
    localparam int YW     = 5;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_write;
    logic [NREQ*TW-1:0]   req_t;
    logic [NREQ*XW-1:0]   req_x;
    logic [NREQ*YW-1:0]   req_y;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [TW-1:0]        mem_t;
    logic [XW-1:0]        mem_x;
    logic [YW-1:0]        mem_y;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;

    mem_arbiter #(
        .NREQ(NREQ), .TW(TW), .XW(XW), .YW(YW), .DW(DW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_t(req_t), .req_x(req_x), .req_y(req_y), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_t(mem_t), .mem_x(mem_x), .mem_y(mem_y), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: data appears in the cycle RD_LAT cycles after the mem_rd cycle has ended, garbage otherwise.
    logic [DW-1:0] memarr [0:4095];
    logic [11:0]   rd_addr;
    bit            rd_pend = 1'b0;
    int            rd_age  = 0;

    initial mem_rdata = 8'hEE;

    always @(negedge clk) begin
        mem_rdata = 8'hEE;
        if (mem_wr) memarr[{mem_t, mem_x, mem_y}] = mem_wdata;
        if (mem_rd) begin
            rd_pend = 1'b1;
            rd_age  = 0;
            rd_addr = {mem_t, mem_x, mem_y};
        end else if (rd_pend) begin
            rd_age++;
            if (rd_age == RD_LAT + 1) begin
                mem_rdata = memarr[rd_addr];
                rd_pend   = 1'b0;
            end
        end
    end

    typedef struct {
        int          req;
        logic        write;
        logic [1:0]  t;
        logic [4:0]  x;
        logic [4:0]  y;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_write = '0;
        req_t     = '0;
        req_x     = '0;
        req_y     = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int r, input logic w, input logic [1:0] t, input logic [4:0] x,
                           input logic [4:0] y, input logic [7:0] d);
        req_valid[r]          = 1'b1;
        req_write[r]          = w;
        req_t[r*TW +: TW]     = t;
        req_x[r*XW +: XW]     = x;
        req_y[r*YW +: YW]     = y;
        req_wdata[r*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_req();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Entered at a negedge with the arbiter idle; leaves the arbiter idle a fraction after a negedge.
    task automatic applyStimulus(input vec_t v, input int n);
        int  seen;
        bit  strobe_bad;
        clear_req();
        set_req(v.req, v.write, v.t, v.x, v.y, v.wdata);
        #1;
        checkOutput($sformatf("v%0d ready", n), 32'(req_ready), 32'(1 << v.req));
        @(negedge clk);
        clear_req();
        #1;
        checkOutput($sformatf("v%0d ready_in_issue", n), 32'(req_ready), 0);
        checkOutput($sformatf("v%0d strobes", n), 32'({mem_rd, mem_wr}), v.write ? 32'd1 : 32'd2);
        checkOutput($sformatf("v%0d addr", n), 32'({mem_t, mem_x, mem_y}), 32'({v.t, v.x, v.y}));
        if (v.write) begin
            checkOutput($sformatf("v%0d wdata", n), 32'(mem_wdata), 32'(v.wdata));
            @(negedge clk);
            #1;
            checkOutput($sformatf("v%0d strobes_after", n), 32'({mem_rd, mem_wr}), 0);
        end else begin
            seen       = 0;
            strobe_bad = 1'b0;
            for (int k = 1; k <= RD_LAT + 6; k++) begin
                @(negedge clk);
                #1;
                if (mem_rd || mem_wr || req_ready != 0) strobe_bad = 1'b1;
                if (rsp_valid != 0) begin
                    seen = k;
                    break;
                end
            end
            checkOutput($sformatf("v%0d latency", n), 32'(seen), 32'(RD_LAT + 2));
            checkOutput($sformatf("v%0d quiet_in_wait", n), 32'(strobe_bad), 0);
            checkOutput($sformatf("v%0d rsp_valid", n), 32'(rsp_valid), 32'(1 << v.req));
            checkOutput($sformatf("v%0d rsp_data", n), 32'(rsp_data), 32'(v.exp_rdata));
            @(negedge clk);
            #1;
            checkOutput($sformatf("v%0d rsp_valid_drop", n), 32'(rsp_valid), 0);
            checkOutput($sformatf("v%0d rsp_data_hold", n), 32'(rsp_data), 32'(v.exp_rdata));
        end
    endtask

    initial begin
        int grants;
        int gidx;
        bit bad;

        vecs[0] = '{0, 1'b0, 2'd1, 5'd3,  5'd4,  8'h00, 8'h5A};
        vecs[1] = '{1, 1'b1, 2'd2, 5'd7,  5'd9,  8'hC3, 8'h00};
        vecs[2] = '{1, 1'b0, 2'd2, 5'd7,  5'd9,  8'h00, 8'hC3};
        vecs[3] = '{2, 1'b1, 2'd3, 5'd31, 5'd0,  8'h81, 8'h00};
        vecs[4] = '{0, 1'b0, 2'd3, 5'd31, 5'd0,  8'h00, 8'h81};
        vecs[5] = '{2, 1'b0, 2'd0, 5'd0,  5'd31, 8'h00, 8'h3C};
        vecs[6] = '{1, 1'b1, 2'd0, 5'd0,  5'd31, 8'hFF, 8'h00};
        vecs[7] = '{2, 1'b0, 2'd0, 5'd0,  5'd31, 8'h00, 8'hFF};

        for (int i = 0; i < 4096; i++) memarr[i] = 8'h00;
        memarr[{2'd1, 5'd3, 5'd4}]  = 8'h5A;
        memarr[{2'd0, 5'd0, 5'd31}] = 8'h3C;

        // Reset with every requester valid: nothing may be granted.
        reset = 1'b1;
        clear_req();
        req_valid = '1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset ready", 32'(req_ready), 0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 0);
        checkOutput("reset strobes", 32'({mem_rd, mem_wr}), 0);
        checkOutput("reset mem_fields", 32'({mem_t, mem_x, mem_y, mem_wdata}), 0);
        checkOutput("reset rsp_data", 32'(rsp_data), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_req();
        #1;
        checkOutput("idle no_valid ready", 32'(req_ready), 0);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        // Reset during WAIT of a read from req1 (pointer moves to 2).
        clear_req();
        set_req(1, 1'b0, 2'd1, 5'd3, 5'd4, 8'h00);
        @(negedge clk);
        clear_req();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        req_valid = '1;
        @(negedge clk);
        #1;
        checkOutput("midrd ready", 32'(req_ready), 0);
        checkOutput("midrd rsp_valid", 32'(rsp_valid), 0);
        checkOutput("midrd strobes", 32'({mem_rd, mem_wr}), 0);
        checkOutput("midrd mem_fields", 32'({mem_t, mem_x, mem_y, mem_wdata}), 0);
        checkOutput("midrd rsp_data", 32'(rsp_data), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midrd grant_from_ptr0", 32'(req_ready), 32'b001);
        clear_req();
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid != 0 || mem_rd || mem_wr) bad = 1'b1;
        end
        checkOutput("midrd no_response", 32'(bad), 0);

        // Fairness: all three continuously valid (writes) from reset.
        do_reset();
        set_req(0, 1'b1, 2'd0, 5'd1, 5'd1, 8'h10);
        set_req(1, 1'b1, 2'd0, 5'd2, 5'd2, 8'h20);
        set_req(2, 1'b1, 2'd0, 5'd3, 5'd3, 8'h30);
        grants = 0;
        for (int k = 0; k < 60 && grants < 9; k++) begin
            #1;
            if (req_ready != 0) begin
                case (req_ready)
                    3'b001:  gidx = 0;
                    3'b010:  gidx = 1;
                    3'b100:  gidx = 2;
                    default: gidx = -1;
                endcase
                checkOutput($sformatf("fair grant%0d", grants), 32'(gidx), 32'(grants % 3));
                grants++;
            end
            @(negedge clk);
        end
        checkOutput("fair grant_count", 32'(grants), 9);
        clear_req();

        // Wrap: req1 moves the pointer to 2; a lone req0 must still win and the pointer moves to 1.
        do_reset();
        set_req(1, 1'b1, 2'd1, 5'd1, 5'd1, 8'h11);
        #1;
        checkOutput("wrap first", 32'(req_ready), 32'b010);
        @(negedge clk);
        clear_req();
        @(negedge clk);
        set_req(0, 1'b1, 2'd1, 5'd2, 5'd2, 8'h22);
        #1;
        checkOutput("wrap req0_only", 32'(req_ready), 32'b001);
        @(negedge clk);
        clear_req();
        @(negedge clk);
        req_valid = '1;
        #1;
        checkOutput("wrap ptr_is_1", 32'(req_ready), 32'b010);
        clear_req();

        // Back-to-back writes from req2.
        @(negedge clk);
        do_reset();
        set_req(2, 1'b1, 2'd3, 5'd1, 5'd2, 8'h77);
        for (int c = 0; c < 8; c++) begin
            #1;
            checkOutput($sformatf("b2b ready c%0d", c), 32'(req_ready), (c % 2 == 0) ? 32'b100 : 32'b000);
            checkOutput($sformatf("b2b mem_wr c%0d", c), 32'(mem_wr), 32'(c % 2));
            if (c % 2 == 1) checkOutput($sformatf("b2b wdata c%0d", c), 32'(mem_wdata), 32'h77);
            @(negedge clk);
        end
        clear_req();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
